system_command_controller: RTL and testbench
============================================

// Module: system_command_controller
// PURPOSE
//   Command-frame decoder and response sequencer in the reference_clk domain, downstream of the UART receiver's data synchronizer.
//   Parses host byte frames: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands.
//   Drives register-file and ALU control, then pushes response bytes into the transmit FIFO that feeds the UART transmitter.
// PARAMETERS
//   DATA_WIDTH            8  width of UART bytes, register-file data and response bytes
//   ADDRESS_WIDTH         4  register-file address width (REGISTER_FILE_DEPTH = 16)
//   ALU_FUNCTION_WIDTH    4  ALU function-code width
//   OPERAND_A_ADDRESS     0  register-file address receiving ALU operand A
//   OPERAND_B_ADDRESS     1  register-file address receiving ALU operand B
// PORTS
//   reference_clk                  in   1                  system clock
//   reset                          in   1                  asynchronous, active-low reset
//   rx_data                        in   DATA_WIDTH         synchronized received byte
//   rx_data_valid                  in   1                  1-cycle pulse, rx_data valid
//   register_file_read_data        in   DATA_WIDTH         register-file read result
//   register_file_read_data_valid  in   1                  1-cycle pulse, read result valid
//   alu_result                     in   2*DATA_WIDTH       ALU result
//   alu_result_valid               in   1                  1-cycle pulse, alu_result valid
//   fifo_full                      in   1                  transmit FIFO cannot accept a write
//   register_file_address          out  ADDRESS_WIDTH      register-file address
//   register_file_write_enable     out  1                  1-cycle write strobe
//   register_file_read_enable      out  1                  1-cycle read strobe
//   register_file_write_data       out  DATA_WIDTH         register-file write data
//   alu_function                   out  ALU_FUNCTION_WIDTH latched ALU function code
//   alu_enable                     out  1                  1-cycle ALU start strobe
//   clock_gate_enable              out  1                  ALU clock-gate enable
//   fifo_write_data                out  DATA_WIDTH         response byte to transmit FIFO
//   fifo_write_enable              out  1                  1-cycle FIFO push strobe
//   command_error                  out  1                  1-cycle pulse, unknown command byte
// BEHAVIOUR
//   Outputs and reset
//   - All outputs are registered; reset (low) forces every output to 0 and the FSM to IDLE immediately.
//   - Reset mid-frame abandons the frame; partial frames and held responses are discarded.
//   - Strobes assert in the cycle after the triggering input pulse and last exactly 1 cycle.
//   FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUNC, ALU_WAIT, SEND_RD, SEND_LO, SEND_HI.
//   - IDLE: rx_data_valid with 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> OP_A; 0xDD -> ALU_FUNC.
//     Any other byte: command_error pulse, stay IDLE.
//   - WR_ADDR: byte[ADDRESS_WIDTH-1:0] latched as address -> WR_DATA.
//   - WR_DATA: byte -> write_enable pulse with latched address and data -> IDLE.
//   - RD_ADDR: byte -> read_enable pulse at that address -> RD_WAIT.
//   - RD_WAIT: register_file_read_data_valid -> capture data -> SEND_RD.
//   - OP_A / OP_B: byte -> write pulse to OPERAND_A_ADDRESS / OPERAND_B_ADDRESS -> next state (OP_A -> OP_B -> ALU_FUNC).
//   - ALU_FUNC: byte[ALU_FUNCTION_WIDTH-1:0] latched into alu_function, alu_enable pulse -> ALU_WAIT.
//   - ALU_WAIT: alu_result_valid -> capture 16-bit result -> SEND_LO.
//   - clock_gate_enable is high only in ALU_FUNC and ALU_WAIT.
//   Response push rules
//   - In SEND_* states, push only when fifo_full == 0; while full, hold fifo_write_data stable and stay in state.
//   - SEND_RD -> IDLE. SEND_LO pushes result[7:0] -> SEND_HI. SEND_HI pushes result[15:8] -> IDLE.
//   Ignored and simultaneous events
//   - rx_data_valid in RD_WAIT, ALU_WAIT or SEND_* is ignored: byte dropped, no error.
//   - read_data_valid / alu_result_valid outside their wait states are ignored.
//   - rx_data_valid coinciding with a result-valid pulse: the result is captured and the byte is dropped.
//   - No timeout: a wait state persists until its valid pulse or reset.
// TESTING
//   - Frame 0xAA,0x05,0x3C -> exactly one write_enable with address=5, data=0x3C; no FIFO push.
//   - Frame 0xBB,0x05; stub returns 0x3C 2 cycles after read_enable -> one read_enable at address 5, then one FIFO push of 0x3C.
//   - Frame 0xCC,0x0A,0x05,0x00; result 0x000F -> writes addr0=0x0A, addr1=0x05, alu_enable with function 0, pushes 0x0F then 0x00.
//   - Frame 0xDD,0x02; fifo_full held high 10 cycles at result -> no push while full, data stable; then pushes 0x32, 0x00 for result 0x0032.
//   - Byte 0x55 in IDLE -> command_error pulse, no strobes; following 0xAA frame completes normally.
//   - Reset low in ALU_WAIT -> all outputs 0 immediately; a later alu_result_valid causes no push; next frame decodes from IDLE.

Source files
------------

// File: rtl/system_command_controller.sv
// Host command-frame decoder: drives register-file / ALU control strobes and
// sequences read or ALU result bytes into the transmit FIFO.
module system_command_controller #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int ALU_FUNCTION_WIDTH = 4,
    parameter int OPERAND_A_ADDRESS  = 0,
    parameter int OPERAND_B_ADDRESS  = 1
) (
    input  logic                          reference_clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_data_valid,
    input  logic [DATA_WIDTH-1:0]         register_file_read_data,
    input  logic                          register_file_read_data_valid,
    input  logic [2*DATA_WIDTH-1:0]       alu_result,
    input  logic                          alu_result_valid,
    input  logic                          fifo_full,
    output logic [ADDRESS_WIDTH-1:0]      register_file_address,
    output logic                          register_file_write_enable,
    output logic                          register_file_read_enable,
    output logic [DATA_WIDTH-1:0]         register_file_write_data,
    output logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
    output logic                          alu_enable,
    output logic                          clock_gate_enable,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic                          fifo_write_enable,
    output logic                          command_error
);

    localparam logic [DATA_WIDTH-1:0] CMD_WRITE   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_READ    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUNC, ALU_WAIT, SEND_RD, SEND_LO, SEND_HI
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] result_hi;

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            state                      <= IDLE;
            result_hi                  <= '0;
            register_file_address      <= '0;
            register_file_write_enable <= 1'b0;
            register_file_read_enable  <= 1'b0;
            register_file_write_data   <= '0;
            alu_function               <= '0;
            alu_enable                 <= 1'b0;
            clock_gate_enable          <= 1'b0;
            fifo_write_data            <= '0;
            fifo_write_enable          <= 1'b0;
            command_error              <= 1'b0;
        end else begin
            register_file_write_enable <= 1'b0;
            register_file_read_enable  <= 1'b0;
            alu_enable                 <= 1'b0;
            fifo_write_enable          <= 1'b0;
            command_error              <= 1'b0;
            case (state)
                IDLE: if (rx_data_valid) begin
                    case (rx_data)
                        CMD_WRITE:   state <= WR_ADDR;
                        CMD_READ:    state <= RD_ADDR;
                        CMD_ALU_OP:  state <= OP_A;
                        CMD_ALU_NOP: begin
                            state             <= ALU_FUNC;
                            clock_gate_enable <= 1'b1;
                        end
                        default:     command_error <= 1'b1;
                    endcase
                end
                WR_ADDR: if (rx_data_valid) begin
                    register_file_address <= rx_data[ADDRESS_WIDTH-1:0];
                    state                 <= WR_DATA;
                end
                WR_DATA: if (rx_data_valid) begin
                    register_file_write_data   <= rx_data;
                    register_file_write_enable <= 1'b1;
                    state                      <= IDLE;
                end
                RD_ADDR: if (rx_data_valid) begin
                    register_file_address     <= rx_data[ADDRESS_WIDTH-1:0];
                    register_file_read_enable <= 1'b1;
                    state                     <= RD_WAIT;
                end
                RD_WAIT: if (register_file_read_data_valid) begin
                    fifo_write_data <= register_file_read_data;
                    state           <= SEND_RD;
                end
                OP_A: if (rx_data_valid) begin
                    register_file_address      <= ADDRESS_WIDTH'(OPERAND_A_ADDRESS);
                    register_file_write_data   <= rx_data;
                    register_file_write_enable <= 1'b1;
                    state                      <= OP_B;
                end
                OP_B: if (rx_data_valid) begin
                    register_file_address      <= ADDRESS_WIDTH'(OPERAND_B_ADDRESS);
                    register_file_write_data   <= rx_data;
                    register_file_write_enable <= 1'b1;
                    clock_gate_enable          <= 1'b1;
                    state                      <= ALU_FUNC;
                end
                ALU_FUNC: if (rx_data_valid) begin
                    alu_function <= rx_data[ALU_FUNCTION_WIDTH-1:0];
                    alu_enable   <= 1'b1;
                    state        <= ALU_WAIT;
                end
                ALU_WAIT: if (alu_result_valid) begin
                    fifo_write_data   <= alu_result[DATA_WIDTH-1:0];
                    result_hi         <= alu_result[2*DATA_WIDTH-1:DATA_WIDTH];
                    clock_gate_enable <= 1'b0;
                    state             <= SEND_LO;
                end
                SEND_RD: if (!fifo_full) begin
                    fifo_write_enable <= 1'b1;
                    state             <= IDLE;
                end
                SEND_LO: if (!fifo_full) begin
                    fifo_write_enable <= 1'b1;
                    state             <= SEND_HI;
                end
                // high byte is presented on entry so it stays put through any stall
                SEND_HI: begin
                    fifo_write_data <= result_hi;
                    if (!fifo_full) begin
                        fifo_write_enable <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_system_command_controller.sv
// Randomized frame bench for system_command_controller with register-file and
// ALU stubs; observed strobes are collected into queues and compared per frame.
module tb_system_command_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic        inj_arv = 1'b0;
    logic [15:0] inj_ar = 16'h0;
    logic        stub_rdv, stub_arv;
    logic [7:0]  stub_rdd;
    logic [15:0] stub_ar;
    logic [3:0]  register_file_address, alu_function;
    logic        register_file_write_enable, register_file_read_enable;
    logic [7:0]  register_file_write_data, fifo_write_data;
    logic        alu_enable, clock_gate_enable, fifo_write_enable, command_error;

    always #5 clk = ~clk;

    system_command_controller dut (
        .reference_clk                (clk),
        .reset                        (rst_n),
        .rx_data                      (rx_data),
        .rx_data_valid                (rx_valid),
        .register_file_read_data      (stub_rdd),
        .register_file_read_data_valid(stub_rdv),
        .alu_result                   (inj_arv ? inj_ar : stub_ar),
        .alu_result_valid             (stub_arv | inj_arv),
        .fifo_full                    (fifo_full),
        .register_file_address        (register_file_address),
        .register_file_write_enable   (register_file_write_enable),
        .register_file_read_enable    (register_file_read_enable),
        .register_file_write_data     (register_file_write_data),
        .alu_function                 (alu_function),
        .alu_enable                   (alu_enable),
        .clock_gate_enable            (clock_gate_enable),
        .fifo_write_data              (fifo_write_data),
        .fifo_write_enable            (fifo_write_enable),
        .command_error                (command_error)
    );

    wire [33:0] all_outs = {register_file_address, register_file_write_enable,
        register_file_read_enable, register_file_write_data, alu_function, alu_enable,
        clock_gate_enable, fifo_write_data, fifo_write_enable, command_error};

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            default: return {8'h00, a ^ b};
        endcase
    endfunction

    // register-file and ALU stubs
    logic [7:0] stub_mem [16];
    logic [3:0] rd_a, af_l;
    int         rd_dly, alu_dly;
    int         alu_lat = 3;
    bit         alu_auto = 1'b1;

    always @(posedge clk) begin
        stub_rdv <= 1'b0;
        stub_arv <= 1'b0;
        if (!rst_n) begin
            rd_dly  <= 0;
            alu_dly <= 0;
            for (int i = 0; i < 16; i++) stub_mem[i] <= 8'h00;
        end else begin
            if (register_file_write_enable) stub_mem[register_file_address] <= register_file_write_data;
            if (rd_dly == 1) begin stub_rdv <= 1'b1; stub_rdd <= stub_mem[rd_a]; end
            if (rd_dly != 0) rd_dly <= rd_dly - 1;
            if (register_file_read_enable) begin rd_dly <= 1; rd_a <= register_file_address; end
            if (alu_dly == 1) begin stub_arv <= 1'b1; stub_ar <= alu_fn(stub_mem[0], stub_mem[1], af_l); end
            if (alu_dly != 0) alu_dly <= alu_dly - 1;
            if (alu_enable && alu_auto) begin alu_dly <= alu_lat; af_l <= alu_function; end
        end
    end

    // observed events
    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$], alu_q[$];
    logic [7:0]  push_q[$], fulldata_q[$];
    bit          err_q[$], full_push_q[$];
    bit          chk_stable = 1'b0;

    always @(negedge clk) if (rst_n) begin
        if (register_file_write_enable) wr_q.push_back({register_file_address, register_file_write_data});
        if (register_file_read_enable)  rd_q.push_back(register_file_address);
        if (alu_enable)                 alu_q.push_back(alu_function);
        if (fifo_write_enable) begin
            push_q.push_back(fifo_write_data);
            if (fifo_full) full_push_q.push_back(1'b1);
        end
        if (command_error) err_q.push_back(1'b1);
        if (chk_stable && fifo_full) fulldata_q.push_back(fifo_write_data);
    end

    int         checks = 0, fails = 0;
    logic [7:0] mdl [16];

    task automatic clear_q();
        wr_q.delete(); rd_q.delete(); alu_q.delete(); push_q.delete();
        fulldata_q.delete(); err_q.delete(); full_push_q.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic wait_push(input int n, input string tag);
        int t = 0;
        while (push_q.size() < n && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (push_q.size() != n) begin
            fails++;
            $display("FAIL %s push_count got=%0d want=%0d", tag, push_q.size(), n);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        clear_q();
        send_byte(8'hAA); send_byte({4'($urandom), a}); send_byte(d);
        settle(3);
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== {a, d}) begin
            fails++;
            $display("FAIL write n=%0d got=%h want=%h", wr_q.size(), wr_q.size() ? wr_q[0] : 12'h0, {a, d});
        end
        checks++;
        if (push_q.size() + rd_q.size() + alu_q.size() + err_q.size() != 0) begin
            fails++;
            $display("FAIL write_extra push=%0d rd=%0d alu=%0d err=%0d", push_q.size(), rd_q.size(), alu_q.size(), err_q.size());
        end
        mdl[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a);
        clear_q();
        send_byte(8'hBB); send_byte({4'($urandom), a});
        wait_push(1, "read");
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== a || push_q.size() != 1 || push_q[0] !== mdl[a]) begin
            fails++;
            $display("FAIL read addr=%h nrd=%0d push=%h want=%h", a, rd_q.size(), push_q.size() ? push_q[0] : 8'h0, mdl[a]);
        end
        checks++;
        if (wr_q.size() != 0) begin fails++; $display("FAIL read_write got=%0d want=0", wr_q.size()); end
    endtask

    task automatic do_alu_cc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        logic [15:0] r;
        clear_q();
        alu_lat = $urandom_range(2, 6);
        send_byte(8'hCC); send_byte(a); send_byte(b); send_byte({4'h0, f});
        checks++;
        if (clock_gate_enable !== 1'b1) begin fails++; $display("FAIL alu_cge_wait got=%b want=1", clock_gate_enable); end
        mdl[0] = a; mdl[1] = b;
        r = alu_fn(mdl[0], mdl[1], f);
        wait_push(2, "alu_cc");
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== {4'd0, a} || wr_q[1] !== {4'd1, b}) begin
            fails++;
            $display("FAIL alu_operands n=%0d want %h,%h", wr_q.size(), {4'd0, a}, {4'd1, b});
        end
        checks++;
        if (alu_q.size() != 1 || alu_q[0] !== f) begin fails++; $display("FAIL alu_func n=%0d want=%h", alu_q.size(), f); end
        checks++;
        if (push_q.size() != 2 || push_q[0] !== r[7:0] || push_q[1] !== r[15:8]) begin
            fails++;
            $display("FAIL alu_result got=%h%h want=%h", push_q.size() > 1 ? push_q[1] : 8'h0, push_q.size() > 0 ? push_q[0] : 8'h0, r);
        end
        settle(1);
        checks++;
        if (clock_gate_enable !== 1'b0) begin fails++; $display("FAIL alu_cge_idle got=%b want=0", clock_gate_enable); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        settle(3);
        checks++;
        if (all_outs !== '0) begin fails++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        settle(2);
    endtask

    task automatic test_write();
        do_write(4'h5, 8'h3C);
        repeat (3) do_write(4'($urandom), 8'($urandom));
    endtask

    task automatic test_read();
        do_read(4'h5);
        repeat (3) do_read(4'($urandom));
    endtask

    task automatic test_alu_operands();
        do_alu_cc(8'h0A, 8'h05, 4'h0);
        repeat (3) do_alu_cc(8'($urandom), 8'($urandom), 4'($urandom_range(0, 3)));
    endtask

    task automatic test_fifo_full();
        logic [15:0] r;
        int t = 0;
        bit bad = 1'b0;
        do_alu_cc(8'h0A, 8'h05, 4'h0);
        clear_q();
        alu_lat = 3;
        send_byte(8'hDD); send_byte(8'h02);
        fifo_full = 1'b1;
        r = alu_fn(mdl[0], mdl[1], 4'h2);
        while (!stub_arv && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        chk_stable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (push_q.size() != 0) begin fails++; $display("FAIL full_no_push got=%0d want=0", push_q.size()); end
        foreach (fulldata_q[i]) if (fulldata_q[i] !== r[7:0]) bad = 1'b1;
        checks++;
        if (bad || fulldata_q.size() < 9) begin
            fails++;
            $display("FAIL full_data_stable n=%0d want=%h", fulldata_q.size(), r[7:0]);
        end
        fifo_full = 1'b0; chk_stable = 1'b0;
        wait_push(2, "full_release");
        checks++;
        if (push_q.size() != 2 || push_q[0] !== 8'h32 || push_q[1] !== 8'h00 || full_push_q.size() != 0) begin
            fails++;
            $display("FAIL full_result got=%h%h want=0032", push_q.size() > 1 ? push_q[1] : 8'h0, push_q.size() > 0 ? push_q[0] : 8'h0);
        end
    endtask

    task automatic test_error();
        logic [7:0] b;
        clear_q();
        send_byte(8'h55);
        settle(2);
        checks++;
        if (err_q.size() != 1 || wr_q.size() + rd_q.size() + alu_q.size() + push_q.size() != 0) begin
            fails++;
            $display("FAIL error_55 err=%0d strobes=%0d want 1,0", err_q.size(), wr_q.size() + rd_q.size() + alu_q.size() + push_q.size());
        end
        do_write(4'hC, 8'h96);
        do begin b = 8'($urandom); end while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
        clear_q();
        send_byte(b);
        settle(2);
        checks++;
        if (err_q.size() != 1) begin fails++; $display("FAIL error_rand byte=%h got=%0d want=1", b, err_q.size()); end
    endtask

    task automatic test_ignored();
        logic [15:0] r;
        clear_q();
        alu_lat = 8;
        send_byte(8'hDD); send_byte(8'h01);
        r = alu_fn(mdl[0], mdl[1], 4'h1);
        send_byte(8'hAA);
        wait_push(2, "drop_wait");
        checks++;
        if (err_q.size() != 0 || wr_q.size() != 0 || push_q.size() != 2 || push_q[0] !== r[7:0] || push_q[1] !== r[15:8]) begin
            fail_line("drop_wait", err_q.size(), wr_q.size());
        end
        // byte arriving in the same cycle as the ALU result
        clear_q();
        alu_lat = 4;
        send_byte(8'hDD); send_byte(8'h03);
        r = alu_fn(mdl[0], mdl[1], 4'h3);
        repeat (alu_lat - 1) @(posedge clk);
        send_byte(8'hBB);
        wait_push(2, "coincident");
        settle(4);
        checks++;
        if (rd_q.size() != 0 || err_q.size() != 0 || push_q.size() != 2 || push_q[0] !== r[7:0]) begin
            fail_line("coincident", err_q.size(), rd_q.size());
        end
        clear_q();
        @(posedge clk); #1;
        inj_arv = 1'b1; inj_ar = 16'hBEEF;
        @(posedge clk); #1;
        inj_arv = 1'b0;
        settle(3);
        checks++;
        if (push_q.size() != 0) begin fails++; $display("FAIL stray_result got=%0d want=0", push_q.size()); end
        do_write(4'h7, 8'h11);
    endtask

    task automatic fail_line(input string tag, input int e, input int s);
        fails++;
        $display("FAIL %s err=%0d strobes=%0d pushes=%0d want 0,0,2", tag, e, s, push_q.size());
    endtask

    task automatic test_reset_mid();
        clear_q();
        alu_auto = 1'b0;
        send_byte(8'hDD); send_byte(8'h03);
        settle(2);
        checks++;
        if (clock_gate_enable !== 1'b1) begin fails++; $display("FAIL rst_pre_cge got=%b want=1", clock_gate_enable); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin fails++; $display("FAIL reset_async got=%h want=0", all_outs); end
        settle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        alu_auto = 1'b1;
        settle(1);
        inj_arv = 1'b1; inj_ar = 16'h1234;
        @(posedge clk); #1;
        inj_arv = 1'b0;
        settle(3);
        checks++;
        if (push_q.size() != 0) begin fails++; $display("FAIL rst_late_result got=%0d want=0", push_q.size()); end
        do_write(4'($urandom), 8'($urandom));
        do_read(4'h3);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_operands();
        test_fifo_full();
        test_error();
        test_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
